// File: rtl/freq_gate_pkg.sv
// Shared definitions for the gate-time frequency counter: FSM state
// encoding, gate-length multipliers and default debounce filter lengths.
package freq_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } fg_state_e;

    localparam int GATE_MULT_0   = 1;
    localparam int GATE_MULT_1   = 10;
    localparam int GATE_MULT_2   = 100;
    localparam int GATE_MULT_3   = 1000;
    localparam int GATE_MULT_MAX = GATE_MULT_3;

    localparam int DEF_FILT_HI = 4;
    localparam int DEF_FILT_LO = 9;

    // Gate length multiplier selected by gate_sel.
    function automatic int gate_mult(input logic [1:0] sel);
        int m;
        case (sel)
            2'd0:    m = GATE_MULT_0;
            2'd1:    m = GATE_MULT_1;
            2'd2:    m = GATE_MULT_2;
            default: m = GATE_MULT_3;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_edge_filter.sv
// edge_filter: two-flop synchronizer on the measured signal followed by a
// pattern shift register (newest sample in the MSB). edge_p fires once per
// qualified rising edge: FILT_HI newest samples high, FILT_LO older ones low.
module edge_filter
    import freq_gate_pkg::*;
#(
    parameter int FILT_HI = DEF_FILT_HI,
    parameter int FILT_LO = DEF_FILT_LO
) (
    input  logic clk_inner,
    input  logic rst,
    input  logic clk_cnt,
    output logic edge_p
);

    localparam int SH_W = FILT_HI + FILT_LO;

    logic [1:0]      sync_q;
    logic [SH_W-1:0] sh_q;

    // Synchronize the asynchronous input and shift it into the pattern window.
    always_ff @(posedge clk_inner) begin
        if (rst) begin
            sync_q <= '0;
            sh_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], clk_cnt};
            sh_q   <= {sync_q[1], sh_q[SH_W-1:1]};
        end
    end

    // Once the high run grows past FILT_HI the oldest high bit lands in the
    // low field, so the pattern can only match a single cycle per edge.
    assign edge_p = (&sh_q[SH_W-1 -: FILT_HI]) && (sh_q[FILT_LO-1:0] == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: counts filtered rising edges of clk_cnt inside a gate of
// GATE_BASE * {1,10,100,1000} clk_inner cycles and latches the result.
// Optional build macro FREQ_GATE_OVF_EN: counter saturates and ovf_o reports
// an edge lost at saturation; otherwise the counter wraps and ovf_o is 0.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for start, gate_sel captured on start
//   ST_ARM   | clear counter/flag, load gate timer (1 cycle)
//   ST_GATE  | count edge_p, decrement timer, exactly G cycles
//   ST_LATCH | copy counter/flag to outputs, valid follows (1 cycle)
module freq_gate_ctrl
    import freq_gate_pkg::*;
#(
    parameter int FILT_HI   = DEF_FILT_HI,
    parameter int FILT_LO   = DEF_FILT_LO,
    parameter int GATE_BASE = 100,
    parameter int CNT_W     = 16
) (
    input  logic             clk_inner,
    input  logic             rst,
    input  logic             clk_cnt,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       gate_sel,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    localparam int TMR_W = $clog2(GATE_BASE * GATE_MULT_MAX + 1);

    fg_state_e        state_q, state_d;
    logic [1:0]       sel_q;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] gate_len;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             edge_p;
    logic             cnt_sat;
    logic             tmr_last;

    edge_filter #(
        .FILT_HI (FILT_HI),
        .FILT_LO (FILT_LO)
    ) u_edge_filter (
        .clk_inner (clk_inner),
        .rst       (rst),
        .clk_cnt   (clk_cnt),
        .edge_p    (edge_p)
    );

    assign gate_len = TMR_W'(GATE_BASE * gate_mult(sel_q));
    assign tmr_last = (tmr_q == TMR_W'(1));

    // FSM state register.
    always_ff @(posedge clk_inner) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; abort only acts while busy and beats gate end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ARM;
            ST_ARM:   state_d = abort ? ST_IDLE : ST_GATE;
            ST_GATE: begin
                if (abort)         state_d = ST_IDLE;
                else if (tmr_last) state_d = ST_LATCH;
            end
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == ST_ARM) || (state_q == ST_GATE);
    end

    // Capture gate selection on the accepted start.
    always_ff @(posedge clk_inner) begin
        if (rst)                                sel_q <= '0;
        else if (state_q == ST_IDLE && start)   sel_q <= gate_sel;
    end

    // Gate timer: loaded in ARM, counts G..1 during GATE.
    always_ff @(posedge clk_inner) begin
        if (rst)                      tmr_q <= '0;
        else if (state_q == ST_ARM)   tmr_q <= gate_len;
        else if (state_q == ST_GATE)  tmr_q <= tmr_q - TMR_W'(1);
    end

`ifdef FREQ_GATE_OVF_EN
    logic ovf_flag_q;
    logic ovf_q;

    assign cnt_sat = &cnt_q;

    // Overflow flag: set by the first edge that arrives at saturation.
    always_ff @(posedge clk_inner) begin
        if (rst)                                         ovf_flag_q <= 1'b0;
        else if (state_q == ST_ARM)                      ovf_flag_q <= 1'b0;
        else if (state_q == ST_GATE && edge_p && cnt_sat) ovf_flag_q <= 1'b1;
    end

    // Latched overflow result.
    always_ff @(posedge clk_inner) begin
        if (rst)                       ovf_q <= 1'b0;
        else if (state_q == ST_LATCH)  ovf_q <= ovf_flag_q;
    end

    assign ovf_o = ovf_q;
`else
    assign cnt_sat = 1'b0;
    assign ovf_o   = 1'b0;
`endif

    // Edge counter: cleared in ARM, counts edge_p only during GATE.
    always_ff @(posedge clk_inner) begin
        if (rst)                                           cnt_q <= '0;
        else if (state_q == ST_ARM)                        cnt_q <= '0;
        else if (state_q == ST_GATE && edge_p && !cnt_sat) cnt_q <= cnt_q + CNT_W'(1);
    end

    // Result latch and one-cycle valid pulse following LATCH.
    always_ff @(posedge clk_inner) begin
        if (rst) begin
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == ST_LATCH);
            if (state_q == ST_LATCH) count_q <= cnt_q;
        end
    end

    assign count_o = count_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl (CNT_W=8 so the overflow case is short).
module tb_freq_gate_ctrl;

    localparam int CNT_W = 8;

    logic             clk_inner = 1'b0;
    logic             rst;
    logic             clk_cnt;
    logic             start;
    logic             abort;
    logic [1:0]       gate_sel;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count_o;
    logic             ovf_o;

    int vectors = 0;
    int errors  = 0;
    int vcount  = 0;
    int gen_per = 0;
    int gen_hi  = 0;
    int ph      = 0;

    freq_gate_ctrl #(
        .FILT_HI   (4),
        .FILT_LO   (9),
        .GATE_BASE (100),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_inner (clk_inner),
        .rst       (rst),
        .clk_cnt   (clk_cnt),
        .start     (start),
        .abort     (abort),
        .gate_sel  (gate_sel),
        .busy      (busy),
        .valid     (valid),
        .count_o   (count_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_inner = ~clk_inner;

    // Periodic measured signal: gen_hi cycles high out of every gen_per.
    initial begin
        clk_cnt = 1'b0;
        forever begin
            @(negedge clk_inner);
            if (gen_per == 0) begin
                clk_cnt = 1'b0;
                ph = 0;
            end else begin
                clk_cnt = (ph < gen_hi);
                ph = (ph + 1 >= gen_per) ? 0 : ph + 1;
            end
        end
    end

    always @(negedge clk_inner) if (valid === 1'b1) vcount++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise start for one cycle; returns #1 after the edge that samples it.
    task automatic do_start(input logic [1:0] sel);
        @(negedge clk_inner);
        gate_sel = sel;
        start    = 1'b1;
        @(posedge clk_inner);
        #1;
        start = 1'b0;
    endtask

    // Edges since start (sampling edge = 1) until valid; 0 on timeout.
    task automatic wait_valid(input int budget, output int lat);
        int n;
        n   = 1;
        lat = 0;
        while (lat == 0 && n < budget) begin
            @(posedge clk_inner);
            #1;
            n++;
            if (valid === 1'b1) lat = n;
        end
    endtask

    initial begin
        int lat;
        int vb;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        gate_sel = 2'd0;

        // Reset state
        repeat (3) @(posedge clk_inner);
        #1;
        check("rst_busy",  busy,    0);
        check("rst_valid", valid,   0);
        check("rst_count", count_o, 0);
        check("rst_ovf",   ovf_o,   0);
        @(negedge clk_inner);
        rst = 1'b0;

        // Period 40, 1000-cycle gate -> 25 edges, valid 1003 cycles after start
        gen_per = 40; gen_hi = 20;
        repeat (60) @(posedge clk_inner);
        do_start(2'd1);
        check("arm_busy", busy, 1);
        wait_valid(1100, lat);
        check("p40_lat",   lat,     1003);
        check("p40_count", count_o, 25);
        check("p40_ovf",   ovf_o,   0);
        @(posedge clk_inner); #1;
        check("valid_pulse_width", valid, 0);
        check("idle_busy", busy, 0);

        // 3-cycle glitches are rejected
        gen_per = 30; gen_hi = 3;
        repeat (60) @(posedge clk_inner);
        do_start(2'd0);
        wait_valid(200, lat);
        check("glitch_lat",   lat,     103);
        check("glitch_count", count_o, 0);

        // 4-cycle pulses qualify: 100-cycle gate / period 25 -> 4
        gen_per = 25; gen_hi = 4;
        repeat (60) @(posedge clk_inner);
        do_start(2'd0);
        wait_valid(200, lat);
        check("pulse4_count", count_o, 4);

        // Overflow: period 20, 10000-cycle gate -> 500 edges into 8 bits
        gen_per = 20; gen_hi = 10;
        repeat (40) @(posedge clk_inner);
        do_start(2'd2);
        wait_valid(10100, lat);
        check("ovf_lat", lat, 10003);
`ifdef FREQ_GATE_OVF_EN
        check("ovf_count", count_o, 255);
        check("ovf_flag",  ovf_o,   1);
`else
        check("ovf_count", count_o, 244);
        check("ovf_flag",  ovf_o,   0);
`endif

        // Start while busy is ignored; start right after valid runs again
        gen_per = 50; gen_hi = 25;
        repeat (60) @(posedge clk_inner);
        vb = vcount;
        do_start(2'd0);
        repeat (30) @(posedge clk_inner);
        @(negedge clk_inner);
        start = 1'b1;
        @(posedge clk_inner); #1;
        start = 1'b0;
        wait_valid(200, lat);
        check("busy_start_lat",   lat + 31, 103);
        check("busy_start_count", count_o,  2);
        do_start(2'd0);
        check("restart_busy", busy, 1);
        wait_valid(200, lat);
        check("restart_lat",   lat,     103);
        check("restart_count", count_o, 2);
        check("restart_ovf",   ovf_o,   0);
        repeat (5) @(posedge clk_inner);
        check("single_valids", vcount - vb, 2);

        // Abort 50 cycles into GATE
        do_start(2'd1);
        repeat (51) @(posedge clk_inner);
        #1;
        check("pre_abort_busy", busy, 1);
        @(negedge clk_inner);
        abort = 1'b1;
        @(posedge clk_inner); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        vb = vcount;
        repeat (1100) @(posedge clk_inner);
        #1;
        check("abort_no_valid", vcount - vb, 0);
        check("abort_count",    count_o,     2);

        // Reset mid-GATE, then a normal measurement
        do_start(2'd1);
        repeat (100) @(posedge clk_inner);
        @(negedge clk_inner);
        rst = 1'b1;
        @(posedge clk_inner); #1;
        check("midrst_busy",  busy,    0);
        check("midrst_valid", valid,   0);
        check("midrst_count", count_o, 0);
        check("midrst_ovf",   ovf_o,   0);
        repeat (2) @(posedge clk_inner);
        @(negedge clk_inner);
        rst = 1'b0;
        repeat (40) @(posedge clk_inner);
        do_start(2'd0);
        wait_valid(200, lat);
        check("post_rst_lat",   lat,     103);
        check("post_rst_count", count_o, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
